// File: rtl/byte_bus_pkg.sv
// rtl/byte_bus_pkg.sv - shared frame types and constants for the byte bus target and CPU handler
package byte_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CTL,
    WDATA,
    WREQ,
    RREQ,
    RWAIT,
    RDATA
  } state_t;

  localparam int CTL_WE_BIT       = 0;
  localparam int FRAME_ADDR_BYTES = 4;
  localparam int FRAME_DATA_BYTES = 4;

  localparam logic [1:0] ADDR_LAST = 2'(FRAME_ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(FRAME_DATA_BYTES - 1);

endpackage

// File: rtl/byte_bus_target_if.sv
// rtl/byte_bus_target_if.sv - byte bus pins plus memory request/response handshake
interface byte_bus_target_if;
  logic        in_valid;
  logic        in_first;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        out_valid;
  logic        out_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  modport slave (
    input  in_valid, in_first, bus_in, out_ready, mem_req_ready, mem_rsp_valid, mem_rdata,
    output bus_out, bus_oe, out_valid, mem_req_valid, mem_addr, mem_we, mem_wdata, busy, err
  );

  modport master (
    output in_valid, in_first, bus_in, out_ready, mem_req_ready, mem_rsp_valid, mem_rdata,
    input  bus_out, bus_oe, out_valid, mem_req_valid, mem_addr, mem_we, mem_wdata, busy, err
  );
endinterface

// File: rtl/byte_shift_reg32.sv
// rtl/byte_shift_reg32.sv - 32-bit word assembled or read out one byte at a time, LSB first
module byte_shift_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_we,
  input  logic [1:0]  idx,
  input  logic [7:0]  byte_in,
  input  logic        word_we,
  input  logic [31:0] word_in,
  output logic [31:0] word_out,
  output logic [7:0]  byte_out
);
  logic [31:0] word;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (word_we) begin
      word <= word_in;
    end else if (byte_we) begin
      word[8*idx +: 8] <= byte_in;
    end
  end

  assign word_out = word;
  assign byte_out = word[8*idx +: 8];
endmodule

// File: rtl/byte_bus_target.sv
// rtl/byte_bus_target.sv - deserializes byte bus frames into word requests and serializes read data back
module byte_bus_target
  import byte_bus_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input logic              clk,
  input logic              rst,
  byte_bus_target_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [1:0]    cnt;
  logic [TW-1:0] tcnt;
  logic          we_q;
  logic          err_q;

  logic          frame_start;
  logic          addr_we;
  logic          wdata_we;
  logic          rsp_take;
  logic          tmo;
  logic [1:0]    addr_idx;
  logic [31:0]   rd_in;
  logic [7:0]    addr_byte_unused;
  logic [7:0]    wdata_byte_unused;

  // An A0 marker is honoured in IDLE and in every collecting state, where it discards the partial frame.
  always_comb begin
    frame_start = bus.in_valid && bus.in_first && (state inside {IDLE, ADDR, CTL, WDATA});
    addr_we     = frame_start || (bus.in_valid && state == ADDR);
    addr_idx    = frame_start ? 2'd0 : cnt;
    wdata_we    = bus.in_valid && !bus.in_first && state == WDATA;
    rsp_take    = state == RWAIT && bus.mem_rsp_valid;
    tmo         = state == RWAIT && !bus.mem_rsp_valid && tcnt == TW'(TIMEOUT);
    rd_in       = rsp_take ? bus.mem_rdata : ERR_WORD;
  end

  byte_shift_reg32 u_addr (
    .clk(clk), .rst(rst), .byte_we(addr_we), .idx(addr_idx), .byte_in(bus.bus_in),
    .word_we(1'b0), .word_in(32'd0), .word_out(bus.mem_addr), .byte_out(addr_byte_unused)
  );

  byte_shift_reg32 u_wdata (
    .clk(clk), .rst(rst), .byte_we(wdata_we), .idx(cnt), .byte_in(bus.bus_in),
    .word_we(1'b0), .word_in(32'd0), .word_out(bus.mem_wdata), .byte_out(wdata_byte_unused)
  );

  byte_shift_reg32 u_rdata (
    .clk(clk), .rst(rst), .byte_we(1'b0), .idx(cnt), .byte_in(8'd0),
    .word_we(rsp_take || tmo), .word_in(rd_in), .word_out(), .byte_out(bus.bus_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            cnt   <= 2'd1;
            state <= ADDR;
          end else if (bus.in_valid) begin
            err_q <= 1'b1;
          end
        end
        ADDR: begin
          if (frame_start) begin
            err_q <= 1'b1;
            cnt   <= 2'd1;
          end else if (bus.in_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == ADDR_LAST) state <= CTL;
          end
        end
        CTL: begin
          if (frame_start) begin
            err_q <= 1'b1;
            cnt   <= 2'd1;
            state <= ADDR;
          end else if (bus.in_valid) begin
            we_q  <= bus.bus_in[CTL_WE_BIT];
            cnt   <= 2'd0;
            state <= bus.bus_in[CTL_WE_BIT] ? WDATA : RREQ;
          end
        end
        WDATA: begin
          if (frame_start) begin
            err_q <= 1'b1;
            cnt   <= 2'd1;
            state <= ADDR;
          end else if (bus.in_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == DATA_LAST) state <= WREQ;
          end
        end
        WREQ: begin
          if (bus.in_valid) err_q <= 1'b1;
          if (bus.mem_req_ready) state <= IDLE;
        end
        RREQ: begin
          if (bus.in_valid) err_q <= 1'b1;
          if (bus.mem_req_ready) begin
            tcnt  <= '0;
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (bus.in_valid) err_q <= 1'b1;
          // A response arriving in the same cycle as the timeout wins.
          if (rsp_take) begin
            cnt   <= 2'd0;
            state <= RDATA;
          end else if (tmo) begin
            err_q <= 1'b1;
            cnt   <= 2'd0;
            state <= RDATA;
          end else if (tcnt < TW'(TIMEOUT)) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RDATA: begin
          if (bus.in_valid) err_q <= 1'b1;
          if (bus.out_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == DATA_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state flops so the request never drops early.
  assign bus.busy          = state != IDLE;
  assign bus.mem_req_valid = state == WREQ || state == RREQ;
  assign bus.mem_we        = we_q;
  assign bus.bus_oe        = state == RDATA;
  assign bus.out_valid     = state == RDATA;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_byte_bus_target.sv
// tb/tb_byte_bus_target.sv - self-checking bench for byte_bus_target
module tb_byte_bus_target;
  import byte_bus_pkg::*;

  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] frame_q[$];

  byte_bus_target_if bus();

  byte_bus_target #(.TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  ctl;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_dly;
    int          rsp_dly;
    int          rdy_mode;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic first, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.bus_in   = b;
    tick;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.bus_in   = 8'h00;
  endtask

  // Frame model: address LSB first, control byte, then data LSB first only for writes.
  task automatic send_frame(input logic [31:0] a, input logic [7:0] ctl, input logic [31:0] d, input int gap_max);
    logic [31:0] t;
    frame_q.delete();
    t = a;
    repeat (4) begin frame_q.push_back(t[7:0]); t = t >> 8; end
    frame_q.push_back(ctl);
    if (ctl[0]) begin
      t = d;
      repeat (4) begin frame_q.push_back(t[7:0]); t = t >> 8; end
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          bus.mem_rsp_valid = 1'($urandom_range(1, 0));
          bus.mem_rdata     = $urandom;
          tick;
        end
        bus.mem_rsp_valid = 1'b0;
      end
      send_byte(i == 0, frame_q[i]);
    end
  endtask

  task automatic accept_req(input logic [31:0] a, input logic we, input logic [31:0] d, input int dly);
    check("req_valid", 32'(bus.mem_req_valid), 32'd1);
    for (int i = 0; i <= dly; i++) begin
      check("req_valid_hold", 32'(bus.mem_req_valid), 32'd1);
      check("req_addr", bus.mem_addr, a);
      check("req_we", 32'(bus.mem_we), 32'(we));
      if (we) check("req_wdata", bus.mem_wdata, d);
      if (i == dly) bus.mem_req_ready = 1'b1;
      tick;
    end
    bus.mem_req_ready = 1'b0;
    check("req_dropped", 32'(bus.mem_req_valid), 32'd0);
    if (we) check("busy_after_write", 32'(bus.busy), 32'd0);
  endtask

  // mode 0: out_ready held high, 1: toggling 1,0,1,0..., 2: random
  task automatic read_back(input logic [31:0] data, input int rsp_dly, input int mode, input logic tmo);
    logic [7:0]  exp_q[$];
    logic [31:0] t;
    int          waited;
    int          guard;
    logic        rdy;
    if (!tmo) begin
      repeat (rsp_dly) begin
        check("no_early_data", 32'(bus.out_valid), 32'd0);
        tick;
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = data;
      tick;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 32'h0;
      check("rsp_latency", 32'(bus.out_valid), 32'd1);
    end else begin
      waited = 0;
      while (!bus.out_valid && waited < TIMEOUT + 10) begin
        tick;
        waited++;
      end
      check("tmo_window", 32'(waited >= TIMEOUT && waited <= TIMEOUT + 2), 32'd1);
    end
    t = tmo ? ERR_WORD : data;
    repeat (4) begin exp_q.push_back(t[7:0]); t = t >> 8; end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2) == 0;
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      bus.out_ready = rdy;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("bus_oe", 32'(bus.bus_oe), 32'd1);
      check("bus_out", 32'(bus.bus_out), 32'(exp_q[0]));
      if (rdy) void'(exp_q.pop_front());
      tick;
      guard++;
    end
    bus.out_ready = 1'b0;
    check("all_bytes_read", 32'(exp_q.size()), 32'd0);
    if (mode == 0) check("four_data_cycles", 32'(guard), 32'd4);
    check("out_valid_end", 32'(bus.out_valid), 32'd0);
    check("bus_oe_end", 32'(bus.bus_oe), 32'd0);
    check("busy_end", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  ctl;
    logic        we;

    bus.in_valid      = 1'b0;
    bus.in_first      = 1'b0;
    bus.bus_in        = 8'h00;
    bus.out_ready     = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    rst = 1'b1;
    tick;
    tick;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_oe", 32'(bus.bus_oe), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_bus_out", 32'(bus.bus_out), 32'd0);
    rst = 1'b0;

    vecs[0] = '{32'h1234_5678, 8'h01, 32'hCAFE_BABE, 32'h0,         3, 0, 0};
    vecs[1] = '{32'h0000_0010, 8'h00, 32'h0,         32'hA1B2_C3D4, 0, 2, 0};
    vecs[2] = '{32'h8000_0001, 8'h00, 32'h0,         32'h0102_0304, 1, 0, 1};
    vecs[3] = '{32'hFFFF_FFFF, 8'hFE, 32'h0,         32'h5566_7788, 2, 5, 0};
    vecs[4] = '{32'h0000_0000, 8'hFF, 32'h0000_0000, 32'h0,         0, 0, 0};
    vecs[5] = '{32'hDEAD_0000, 8'h01, 32'hFFFF_FFFF, 32'h0,         0, 0, 0};

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].addr, vecs[i].ctl, vecs[i].wdata, 0);
      accept_req(vecs[i].addr, vecs[i].ctl[0], vecs[i].wdata, vecs[i].ready_dly);
      if (!vecs[i].ctl[0]) read_back(vecs[i].rdata, vecs[i].rsp_dly, vecs[i].rdy_mode, 1'b0);
      check("vec_err", 32'(bus.err), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      d   = $urandom;
      we  = 1'($urandom_range(1, 0));
      ctl = 8'($urandom);
      ctl[0] = we;
      send_frame(a, ctl, d, 2);
      accept_req(a, we, d, $urandom_range(3, 0));
      if (!we) read_back($urandom, $urandom_range(4, 0), 2, 1'b0);
      check("rand_err", 32'(bus.err), 32'd0);
    end

    // Response arriving just before the timeout must still be delivered.
    send_frame(32'h0000_0044, 8'h00, 32'h0, 0);
    accept_req(32'h0000_0044, 1'b0, 32'h0, 0);
    read_back(32'h1357_9BDF, TIMEOUT - 1, 0, 1'b0);
    check("late_rsp_err", 32'(bus.err), 32'd0);

    send_frame(32'h0000_2000, 8'h00, 32'h0, 0);
    accept_req(32'h0000_2000, 1'b0, 32'h0, 0);
    read_back(32'h0, 0, 0, 1'b1);
    check("tmo_err", 32'(bus.err), 32'd1);

    do_reset();
    check("err_cleared", 32'(bus.err), 32'd0);
    send_byte(1'b1, 8'h11);
    send_byte(1'b0, 8'h22);
    check("partial_no_req", 32'(bus.mem_req_valid), 32'd0);
    send_frame(32'h0BAD_F00D, 8'h00, 32'h0, 0);
    accept_req(32'h0BAD_F00D, 1'b0, 32'h0, 0);
    read_back(32'h2468_ACE0, 1, 0, 1'b0);
    check("restart_err", 32'(bus.err), 32'd1);

    do_reset();
    send_frame(32'h0000_0300, 8'h01, 32'h0000_0077, 0);
    check("wreq_valid", 32'(bus.mem_req_valid), 32'd1);
    send_byte(1'b0, 8'h99);
    check("stray_in_wreq_err", 32'(bus.err), 32'd1);
    check("wreq_still_valid", 32'(bus.mem_req_valid), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_wreq_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_wreq_busy", 32'(bus.busy), 32'd0);
    check("rst_wreq_err", 32'(bus.err), 32'd0);
    send_frame(32'h0000_0400, 8'h01, 32'h0000_ABCD, 0);
    accept_req(32'h0000_0400, 1'b1, 32'h0000_ABCD, 1);
    check("post_rst_err", 32'(bus.err), 32'd0);

    send_byte(1'b0, 8'h5A);
    check("idle_stray_err", 32'(bus.err), 32'd1);
    check("idle_stray_busy", 32'(bus.busy), 32'd0);
    check("idle_stray_req", 32'(bus.mem_req_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
